ram_delay_line_prog: RTL and testbench

//  Multi-channel RAM-based delay line with a delay programmable at run time.

---
 rtl/ram_delay_line_prog.sv | 134 +++++++++++++
 tb/tb_ram_delay_line_prog.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ram_delay_line_prog.sv
// ---------------------------------------------------------------------------
// ram_delay_line_prog
//   Multi-channel RAM-based delay line with a run-time programmable delay.
//   All lanes share one circular buffer word (lane0 in the LSBs) and one
//   address generator. The output stays masked to zero until the line has
//   filled.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous reset, active low
//   ce         : clock enable, advances the line by one sample
//   delay_load : load delay_in as the new delay (independent of ce)
//   delay_in   : requested delay, MIN_DELAY..MAX_DELAY accepted
//   data_in    : sample, captured on ce edges
//   data_out   : delayed sample, 0 while out_valid is low
//   out_valid  : line filled, data_out meaningful
//   delay_cur  : delay currently in force
//   cfg_err    : one-cycle pulse after a rejected delay_load
// ---------------------------------------------------------------------------
module ram_delay_line_prog #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned MAX_DELAY     = 64,
    parameter int unsigned DEFAULT_DELAY = 64,
    localparam int unsigned DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ce,
    input  logic                           delay_load,
    input  logic [DW-1:0]                  delay_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           out_valid,
    output logic [DW-1:0]                  delay_cur,
    output logic                           cfg_err
);

    localparam int unsigned MIN_DELAY = 3;
    localparam int unsigned AW        = $clog2(MAX_DELAY);
    localparam int unsigned WW        = CHANNELS * DATA_WIDTH;

    logic [WW-1:0] mem [0:MAX_DELAY-1];

    logic [DW-1:0] delay_q, delay_d;
    logic [DW-1:0] wptr_q,  wptr_d;
    logic [DW-1:0] fill_q,  fill_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [WW-1:0] rd_q,    rd_d;
    logic [WW-1:0] data_q,  data_d;
    logic          valid_q, valid_d;
    logic          err_q,   err_d;
    logic          we;
    logic          load_ok;
    logic [DW:0]   raddr_sum;

    assign load_ok = (delay_in >= DW'(MIN_DELAY)) && (delay_in <= DW'(MAX_DELAY));

    // Read address leads the write pointer by MIN_DELAY (mod D): the
    // registered address, the registered RAM read and the output register
    // together make up the remaining D-1 ce edges.
    assign raddr_sum = {1'b0, wptr_q} + (DW + 1)'(MIN_DELAY);

    always_comb begin
        delay_d = delay_q;
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        raddr_d = raddr_q;
        rd_d    = rd_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        we      = 1'b0;

        if (delay_load && load_ok) begin
            // Accepted load restarts the line; this edge's data_in is dropped.
            delay_d = delay_in;
            wptr_d  = '0;
            fill_d  = '0;
            valid_d = 1'b0;
            data_d  = '0;
        end else begin
            // A rejected load only raises cfg_err; the stream keeps running.
            err_d = delay_load;
            if (ce) begin
                we      = 1'b1;
                wptr_d  = (wptr_q == delay_q - DW'(1)) ? '0 : wptr_q + DW'(1);
                fill_d  = (fill_q == delay_q) ? fill_q : fill_q + DW'(1);
                raddr_d = (raddr_sum >= {1'b0, delay_q}) ?
                          AW'(raddr_sum - {1'b0, delay_q}) : AW'(raddr_sum);
                rd_d    = mem[raddr_q];
                data_d  = rd_q;
                if (fill_q >= delay_q - DW'(1)) begin
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delay_q <= DW'(DEFAULT_DELAY);
            wptr_q  <= '0;
            fill_q  <= '0;
            raddr_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            delay_q <= delay_d;
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            raddr_q <= raddr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; stale words are hidden by the fill mask.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[wptr_q[AW-1:0]] <= data_in;
        end
    end

    assign data_out  = valid_q ? data_q : '0;
    assign out_valid = valid_q;
    assign delay_cur = delay_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_ram_delay_line_prog.sv
// ---------------------------------------------------------------------------
// tb_ram_delay_line_prog
//   Scoreboard bench for ram_delay_line_prog with default parameters.
//   Each driven cycle pushes the expected outputs, derived from a sample
//   history model, and pops/compares them one cycle later.
// ---------------------------------------------------------------------------
module tb_ram_delay_line_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        delay_load;
    logic [6:0]  delay_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        out_valid;
    logic [6:0]  delay_cur;
    logic        cfg_err;

    always #5 clk = ~clk;

    ram_delay_line_prog #(
        .DATA_WIDTH    (8),
        .CHANNELS      (4),
        .MAX_DELAY     (64),
        .DEFAULT_DELAY (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .delay_load (delay_load),
        .delay_in   (delay_in),
        .data_in    (data_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .delay_cur  (delay_cur),
        .cfg_err    (cfg_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic [6:0]  dcur;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hist[$];
    int          m_d;
    logic        m_v;
    logic [31:0] m_dat;
    logic        m_err;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int base, input int stride);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'((base + stride * k) & 255);
        return w;
    endfunction

    task automatic step(input logic r, input logic l, input logic [6:0] din,
                        input logic c, input logic [31:0] d, input string tag);
        exp_t e;
        int   n;
        rst_n = r; delay_load = l; delay_in = din; ce = c; data_in = d;
        if (!r) begin
            m_d = 64; hist.delete(); m_v = 0; m_dat = '0; m_err = 0;
        end else if (l && din >= 3 && din <= 64) begin
            m_d = int'(din); hist.delete(); m_v = 0; m_dat = '0; m_err = 0;
        end else begin
            m_err = l;
            if (c) begin
                hist.push_back(d);
                n = hist.size() - 1;
                if (n >= m_d - 1) begin
                    m_v   = 1;
                    m_dat = hist[n - m_d + 1];
                end
            end
        end
        e.data = m_v ? m_dat : '0;
        e.valid = m_v;
        e.dcur = 7'(m_d);
        e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"},  data_out,          e.data);
            chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, e.valid});
            chk({tag, "_dcur"},  {25'd0, delay_cur}, {25'd0, e.dcur});
            chk({tag, "_err"},   {31'd0, cfg_err},   {31'd0, e.err});
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; delay_load = 1'b0; delay_in = '0; data_in = '0;
        m_d = 64; m_v = 0; m_dat = '0; m_err = 0;
        @(posedge clk); #1;
        step(0, 0, 0, 1, 32'hdeadbeef, "rst");
        step(0, 0, 0, 0, 32'h0, "rst");

        // 1: default delay 64, lane k = 16k + n
        for (int n = 0; n < 70; n++) begin
            step(1, 0, 0, 1, pack(n, 16), "t1");
            if (n == 62) chk("t1_valid_62", {31'd0, out_valid}, 32'd0);
            if (n >= 63) chk("t1_lane0", {24'd0, data_out[7:0]}, 32'((n - 63) & 255));
        end

        // 2: delay 3, long ramp across many pointer wraps
        step(1, 1, 3, 0, 32'h0, "t2_load");
        for (int n = 0; n < 200; n++) begin
            step(1, 0, 0, 1, pack(4 * n, 1), "t2");
            if (n >= 2) chk("t2_lane0", {24'd0, data_out[7:0]}, 32'((4 * (n - 2)) & 255));
        end

        // 3: delay 5, ce pattern 1,0,0
        step(1, 1, 5, 1, 32'h11111111, "t3_load");
        for (int i = 0; i < 60; i++) begin
            step(1, 0, 0, (i % 3 == 0), pack(100 + i, 7), "t3");
        end

        // 4: mid-stream load of 10 with ce on the same edge
        step(1, 1, 10, 1, 32'hcafef00d, "t4_load");
        chk("t4_valid_clr", {31'd0, out_valid}, 32'd0);
        chk("t4_data_clr", data_out, 32'd0);
        for (int n = 0; n < 30; n++) begin
            step(1, 0, 0, 1, pack(3 * n + 1, 5), "t4");
        end

        // 5: rejected loads (2 and 65) keep the stream running
        step(1, 1, 2, 0, 32'h0, "t5_bad2");
        chk("t5_err2", {31'd0, cfg_err}, 32'd1);
        for (int n = 0; n < 4; n++) step(1, 0, 0, 1, pack(200 + n, 9), "t5a");
        step(1, 1, 65, 0, 32'h0, "t5_bad65");
        chk("t5_err65", {31'd0, cfg_err}, 32'd1);
        step(1, 0, 0, 0, 32'h0, "t5_errdrop");
        for (int n = 0; n < 12; n++) step(1, 0, 0, 1, pack(50 + n, 13), "t5b");

        // 6: reset mid-stream with ce low; reset wins over a load
        step(0, 0, 0, 0, 32'h0, "t6_rst");
        chk("t6_dcur64", {25'd0, delay_cur}, 32'd64);
        for (int n = 0; n < 5; n++) step(1, 0, 0, 1, pack(n, 2), "t6a");
        step(0, 1, 5, 1, 32'h0, "t6_rst_load");
        chk("t6_rst_wins", {25'd0, delay_cur}, 32'd64);
        for (int n = 0; n < 70; n++) step(1, 0, 0, 1, pack(9 * n, 3), "t6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
